// File: rtl/ctr_pkg.sv
// rtl/ctr_pkg.sv - shared encodings for the up/down modulus counter family
//   Exports: end-mode encodings (MODE_*) and the run/done FSM state type.
package ctr_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'd0;
  localparam logic [1:0] MODE_SAT     = 2'd1;
  localparam logic [1:0] MODE_ONESHOT = 2'd2;
  // 2'd3 is reserved and is treated exactly like MODE_WRAP.

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } ctr_state_e;

endpackage

// File: rtl/updown_mod_counter_if.sv
// rtl/updown_mod_counter_if.sv - control/status bundle of the up/down modulus counter
//   Controls (master -> slave): en, up, mode[1:0], clr, load, load_val[WIDTH-1:0]
//   Status   (slave -> master): count[WIDTH-1:0], tc, done
interface updown_mod_counter_if #(
  parameter int WIDTH = 12
);

  logic             en;
  logic             up;
  logic [1:0]       mode;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             done;

  modport master (
    output en, up, mode, clr, load, load_val,
    input  count, tc, done
  );

  modport slave (
    input  en, up, mode, clr, load, load_val,
    output count, tc, done
  );

endinterface

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - enable-gated divide-by-PRESCALE tick generator
//   clk      in   rising-edge clock
//   rst      in   asynchronous reset, active-high
//   en       in   phase advances only while high
//   sync_clr in   synchronous return to phase 0 (wins over en)
//   tick     out  high during the enabled cycle that completes a PRESCALE period
module tick_prescaler #(
  parameter int PRESCALE = 1,
  parameter int PS_W     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sync_clr,
  output logic tick
);

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

  logic [PS_W-1:0] phase_q;
  logic            at_last;

  assign at_last = (phase_q == PS_LAST);
  // A clearing cycle never ticks, so the owner can treat clr as highest priority.
  assign tick    = en & ~sync_clr & at_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
    end else if (sync_clr) begin
      phase_q <= '0;
    end else if (en) begin
      phase_q <= at_last ? '0 : phase_q + PS_ONE;
    end
  end

endmodule

// File: rtl/updown_mod_counter.sv
// rtl/updown_mod_counter.sv - prescaled up/down counter over 0..MAX with wrap/saturate/one-shot ends
//   clk    in   rising-edge clock
//   rst    in   asynchronous reset, active-high
//   bus    slave modport of updown_mod_counter_if:
//            en, up, mode, clr, load, load_val in; count, tc, done out (all registered)
module updown_mod_counter
  import ctr_pkg::*;
#(
  parameter int WIDTH    = 12,
  parameter int MAX      = 4095,
  parameter int PRESCALE = 1,
  parameter int PS_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  updown_mod_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  ctr_state_e       state_q, state_d;

  logic             sync_clr;
  logic             tick;
  logic             step;
  logic             at_term;

  assign sync_clr = bus.clr | bus.load;

  tick_prescaler #(
    .PRESCALE (PRESCALE),
    .PS_W     (PS_W)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (bus.en),
    .sync_clr (sync_clr),
    .tick     (tick)
  );

  // The prescaler keeps running in DONE; only the step itself is suppressed.
  assign step    = tick & (state_q == ST_RUN);
  assign at_term = bus.up ? (count_q == MAX_V) : (count_q == '0);

  always_comb begin
    count_d = count_q;
    state_d = state_q;
    tc_d    = 1'b0;

    if (bus.clr) begin
      count_d = '0;
      state_d = ST_RUN;
    end else if (bus.load) begin
      count_d = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;
      state_d = ST_RUN;
    end else if (state_q == ST_DONE) begin
      // Leaving one-shot mode releases the counter; the release cycle itself never steps.
      if (bus.mode != MODE_ONESHOT) begin
        state_d = ST_RUN;
      end
    end else if (step) begin
      if (!at_term) begin
        count_d = bus.up ? count_q + ONE_V : count_q - ONE_V;
      end else begin
        tc_d = 1'b1;
        case (bus.mode)
          MODE_SAT:     count_d = count_q;
          MODE_ONESHOT: state_d = ST_DONE;
          // Explicit wrap so a non-power-of-two MAX never relies on overflow.
          default:      count_d = bus.up ? '0 : MAX_V;
        endcase
      end
    end

    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
      state_q <= ST_RUN;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
      state_q <= state_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb/tb_updown_mod_counter.sv - directed self-checking bench for updown_mod_counter
module tb_updown_mod_counter;

  localparam int W   = 4;
  localparam int MX  = 9;
  localparam int PSA = 1;
  localparam int PSB = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         up = 1'b1;
  logic [1:0]   mode = 2'd0;
  logic         clr = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  updown_mod_counter_if #(.WIDTH(W)) ifa ();
  updown_mod_counter_if #(.WIDTH(W)) ifb ();

  assign ifa.en = en;   assign ifb.en = en;
  assign ifa.up = up;   assign ifb.up = up;
  assign ifa.mode = mode; assign ifb.mode = mode;
  assign ifa.clr = clr; assign ifb.clr = clr;
  assign ifa.load = load; assign ifb.load = load;
  assign ifa.load_val = load_val; assign ifb.load_val = load_val;

  updown_mod_counter #(.WIDTH(W), .MAX(MX), .PRESCALE(PSA), .PS_W(8)) dut_a (
    .clk (clk), .rst (rst), .bus (ifa)
  );

  updown_mod_counter #(.WIDTH(W), .MAX(MX), .PRESCALE(PSB), .PS_W(8)) dut_b (
    .clk (clk), .rst (rst), .bus (ifb)
  );

  // Behavioural model: count as an integer in 0..MX, phase as enabled cycles mod PRESCALE.
  typedef struct packed {
    int   cnt;
    int   ph;
    logic done;
    logic tc;
  } model_t;

  model_t ma, mb;

  function automatic model_t mnext(model_t m, int pres);
    model_t n;
    bit     fires;
    bit     at_end;
    n    = m;
    n.tc = 1'b0;
    if (clr) begin
      n.cnt = 0; n.ph = 0; n.done = 1'b0;
    end else if (load) begin
      n.cnt = (int'(load_val) > MX) ? MX : int'(load_val);
      n.ph = 0; n.done = 1'b0;
    end else begin
      if (m.done && mode != 2'd2) n.done = 1'b0;
      fires = 1'b0;
      if (en) begin
        fires = (m.ph == pres - 1) && !m.done;
        n.ph  = (m.ph + 1) % pres;
      end
      if (fires) begin
        at_end = up ? (m.cnt == MX) : (m.cnt == 0);
        if (at_end) n.tc = 1'b1;
        if (at_end && mode == 2'd1) begin
          n.cnt = m.cnt;
        end else if (at_end && mode == 2'd2) begin
          n.done = 1'b1;
        end else begin
          n.cnt = up ? (m.cnt + 1) % (MX + 1) : (m.cnt + MX) % (MX + 1);
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma <= '0;
      mb <= '0;
    end else begin
      ma <= mnext(ma, PSA);
      mb <= mnext(mb, PSB);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("model_a.count", int'(ifa.count), ma.cnt);
    chk("model_a.tc",    int'(ifa.tc),    int'(ma.tc));
    chk("model_a.done",  int'(ifa.done),  int'(ma.done));
    chk("model_b.count", int'(ifb.count), mb.cnt);
    chk("model_b.tc",    int'(ifb.tc),    int'(mb.tc));
    chk("model_b.done",  int'(ifb.done),  int'(mb.done));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int exp1 [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int exp3 [5]  = '{8, 9, 9, 9, 9};
  int exp4c [7] = '{8, 8, 9, 9, 9, 9, 9};
  int exp4d [7] = '{0, 0, 0, 0, 0, 1, 1};
  int exp4t [7] = '{0, 0, 0, 0, 0, 1, 0};

  initial begin
    // Reset state
    cyc(); cyc();
    chk("reset.count", int'(ifa.count), 0);
    chk("reset.tc",    int'(ifa.tc),    0);
    chk("reset.done",  int'(ifa.done),  0);
    rst = 1'b0;

    // 1: wrap up over 0..9
    en = 1'b1; up = 1'b1; mode = 2'd0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      chk("t1.count", int'(ifa.count), exp1[i]);
      chk("t1.tc",    int'(ifa.tc),    (i == 9) ? 1 : 0);
    end
    en = 1'b0;
    cyc(); cyc();
    chk("hold.count", int'(ifa.count), 2);
    chk("hold.tc",    int'(ifa.tc),    0);

    // 2: wrap down from 0
    clr = 1'b1; cyc(); clr = 1'b0;
    chk("t2.clr", int'(ifa.count), 0);
    up = 1'b0; en = 1'b1;
    cyc(); chk("t2.count0", int'(ifa.count), 9); chk("t2.tc0", int'(ifa.tc), 1);
    cyc(); chk("t2.count1", int'(ifa.count), 8); chk("t2.tc1", int'(ifa.tc), 0);
    cyc(); chk("t2.count2", int'(ifa.count), 7);

    // 3: saturate at 9
    mode = 2'd1; up = 1'b1; load_val = 4'd7; load = 1'b1;
    cyc(); load = 1'b0;
    chk("t3.load", int'(ifa.count), 7);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t3.count", int'(ifa.count), exp3[i]);
      chk("t3.tc",    int'(ifa.tc),    (i >= 2) ? 1 : 0);
    end

    // 4: one-shot with PRESCALE=3 on dut_b
    mode = 2'd2; load_val = 4'd8; load = 1'b1;
    cyc(); load = 1'b0;
    chk("t4.load", int'(ifb.count), 8);
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk("t4.count", int'(ifb.count), exp4c[i]);
      chk("t4.done",  int'(ifb.done),  exp4d[i]);
      chk("t4.tc",    int'(ifb.tc),    exp4t[i]);
    end
    cyc(); cyc(); cyc();
    chk("t4.hold_count", int'(ifb.count), 9);
    chk("t4.hold_done",  int'(ifb.done),  1);
    clr = 1'b1; cyc(); clr = 1'b0;
    chk("t4.clr_count", int'(ifb.count), 0);
    chk("t4.clr_done",  int'(ifb.done),  0);

    // 5: load clamp and clr-over-load priority
    mode = 2'd0; load_val = 4'd15; load = 1'b1;
    cyc();
    chk("t5.clamp_a", int'(ifa.count), 9);
    chk("t5.clamp_b", int'(ifb.count), 9);
    clr = 1'b1;
    cyc(); clr = 1'b0; load = 1'b0;
    chk("t5.prio", int'(ifa.count), 0);

    // 6: async reset mid-count, prescaler mid-phase
    load_val = 4'd3; load = 1'b1;
    cyc(); load = 1'b0;
    for (int i = 0; i < 7; i++) cyc();
    chk("t6.pre", int'(ifb.count), 5);
    #2 rst = 1'b1;
    #1;
    chk("t6.rst_count", int'(ifb.count), 0);
    chk("t6.rst_tc",    int'(ifb.tc),    0);
    chk("t6.rst_done",  int'(ifb.done),  0);
    cyc(); rst = 1'b0;
    cyc(); chk("t6.c1", int'(ifb.count), 0);
    cyc(); chk("t6.c2", int'(ifb.count), 0);
    cyc(); chk("t6.c3", int'(ifb.count), 1);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
